// File: rtl/clk_div_prog.sv
// Programmable clock divider with a square or pulse output.
// New divisors are held in a shadow register and applied only at half-period boundaries.
module clk_div_prog #(
    parameter int          CNT_W     = 26,
    parameter int unsigned HALF_INIT = 6250000
) (
    input  logic             clkIn,
    input  logic             rstN,
    input  logic             en,
    input  logic             clr,
    input  logic             divLoad,
    input  logic [CNT_W-1:0] divIn,
    input  logic             pulseMode,
    output logic             clkOut,
    output logic             tick,
    output logic             pending,
    output logic [CNT_W-1:0] halfAct
);

    localparam logic [CNT_W-1:0] HALF_RST = HALF_INIT[CNT_W-1:0];
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             toggle_q, toggle_d;
    logic             tick_q, tick_d;
    logic             clkout_q, clkout_d;
    logic             pending_q, pending_d;

    logic [CNT_W-1:0] div_fix;
    logic             wrap;

    always_comb begin
        div_fix = (divIn == '0) ? ONE : divIn;
        wrap    = en && (cnt_q == half_q - ONE);
    end

    always_comb begin
        cnt_d     = cnt_q;
        half_d    = half_q;
        shadow_d  = shadow_q;
        toggle_d  = toggle_q;
        pending_d = pending_q;
        tick_d    = 1'b0;

        if (clr) begin
            cnt_d    = '0;
            toggle_d = 1'b0;
            if (divLoad) begin
                half_d    = div_fix;
                shadow_d  = div_fix;
                pending_d = 1'b0;
            end else if (pending_q) begin
                half_d    = shadow_q;
                pending_d = 1'b0;
            end
        end else if (divLoad && !en) begin
            // Idle divider: nothing to protect, apply at once.
            cnt_d     = '0;
            half_d    = div_fix;
            shadow_d  = div_fix;
            pending_d = 1'b0;
        end else if (en) begin
            if (wrap) begin
                cnt_d    = '0;
                toggle_d = ~toggle_q;
                tick_d   = 1'b1;
                if (divLoad) begin
                    half_d    = div_fix;
                    shadow_d  = div_fix;
                    pending_d = 1'b0;
                end else if (pending_q) begin
                    half_d    = shadow_q;
                    pending_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + ONE;
                if (divLoad) begin
                    shadow_d  = div_fix;
                    pending_d = 1'b1;
                end
            end
        end

        clkout_d = pulseMode ? tick_d : toggle_d;
    end

    always_ff @(posedge clkIn or negedge rstN) begin
        if (!rstN) begin
            cnt_q     <= '0;
            half_q    <= HALF_RST;
            shadow_q  <= HALF_RST;
            toggle_q  <= 1'b0;
            tick_q    <= 1'b0;
            clkout_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            shadow_q  <= shadow_d;
            toggle_q  <= toggle_d;
            tick_q    <= tick_d;
            clkout_q  <= clkout_d;
            pending_q <= pending_d;
        end
    end

    assign clkOut  = clkout_q;
    assign tick    = tick_q;
    assign pending = pending_q;
    assign halfAct = half_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: countdown reference model plus directed scenarios.
module tb_clk_div_prog;

    localparam int W = 8;

    logic         clkIn = 1'b0;
    logic         rstN = 1'b1;
    logic         en = 1'b0;
    logic         clr = 1'b0;
    logic         divLoad = 1'b0;
    logic [W-1:0] divIn = '0;
    logic         pulseMode = 1'b0;
    logic         clkOut;
    logic         tick;
    logic         pending;
    logic [W-1:0] halfAct;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk = 1'b0;

    clk_div_prog #(.CNT_W(W), .HALF_INIT(4)) dut (
        .clkIn(clkIn),
        .rstN(rstN),
        .en(en),
        .clr(clr),
        .divLoad(divLoad),
        .divIn(divIn),
        .pulseMode(pulseMode),
        .clkOut(clkOut),
        .tick(tick),
        .pending(pending),
        .halfAct(halfAct)
    );

    always #5 clkIn = ~clkIn;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Reference: counts down the cycles remaining in the current half-period.
    int   m_rem = 4;
    int   m_half = 4;
    int   m_shadow = 4;
    logic m_lvl = 1'b0;
    logic m_tick = 1'b0;
    logic m_out = 1'b0;
    logic m_pend = 1'b0;

    always @(posedge clkIn or negedge rstN) begin
        int d, h, s, r;
        logic l, t, p;
        if (!rstN) begin
            m_rem <= 4; m_half <= 4; m_shadow <= 4;
            m_lvl <= 1'b0; m_tick <= 1'b0; m_out <= 1'b0; m_pend <= 1'b0;
        end else begin
            d = (divIn == 0) ? 1 : int'(divIn);
            h = m_half; s = m_shadow; r = m_rem;
            l = m_lvl; p = m_pend; t = 1'b0;
            if (clr) begin
                l = 1'b0;
                if (divLoad) begin h = d; s = d; p = 1'b0; end
                else if (p) begin h = s; p = 1'b0; end
                r = h;
            end else if (divLoad && !en) begin
                h = d; s = d; p = 1'b0; r = h;
            end else if (en) begin
                if (r == 1) begin
                    l = ~l; t = 1'b1;
                    if (divLoad) begin h = d; s = d; p = 1'b0; end
                    else if (p) begin h = s; p = 1'b0; end
                    r = h;
                end else begin
                    r = r - 1;
                    if (divLoad) begin s = d; p = 1'b1; end
                end
            end
            m_rem <= r; m_half <= h; m_shadow <= s;
            m_lvl <= l; m_tick <= t; m_pend <= p;
            m_out <= pulseMode ? t : l;
        end
    end

    always @(negedge clkIn) begin
        if (chk) begin
            check("model_clkOut", clkOut, m_out);
            check("model_tick", tick, m_tick);
            check("model_pending", pending, m_pend);
            check("model_halfAct", halfAct, m_half);
        end
    end

    task automatic measure_rise(output int n);
        logic prev;
        prev = clkOut;
        n = 0;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clkIn);
            if (!prev && clkOut) begin
                n = i;
                break;
            end
            prev = clkOut;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clkIn);
    endtask

    initial begin
        int n;
        int k;
        #2 rstN = 1'b0;
        #1 chk = 1'b1;
        check("rst_clkOut", clkOut, 0);
        check("rst_halfAct", halfAct, 4);
        check("rst_pending", pending, 0);
        cyc(2);

        // Release with en=1: first rise after 4 cycles, then period 8
        rstN = 1'b1; en = 1'b1;
        measure_rise(n);
        check("first_rise", n, 4);
        measure_rise(n);
        check("period_8", n, 8);

        // Load 2 at cnt=1: waits for the running half, then period 4
        cyc(1);
        divLoad = 1'b1; divIn = 8'd2;
        cyc(1);
        divLoad = 1'b0;
        check("pend_set", pending, 1);
        check("half_hold", halfAct, 4);
        k = 0;
        while (pending && k < 20) begin cyc(1); k++; end
        check("pend_clear", pending, 0);
        check("half_2", halfAct, 2);
        measure_rise(n);
        measure_rise(n);
        check("period_4", n, 4);

        // Idle load of 0 becomes 1: clkIn/2
        en = 1'b0; divLoad = 1'b1; divIn = 8'd0;
        cyc(1);
        divLoad = 1'b0;
        check("half_1", halfAct, 1);
        check("idle_pend", pending, 0);
        en = 1'b1;
        measure_rise(n);
        measure_rise(n);
        check("period_2", n, 2);

        // Pulse mode with half 3
        en = 1'b0; divLoad = 1'b1; divIn = 8'd3;
        cyc(1);
        divLoad = 1'b0; pulseMode = 1'b1; en = 1'b1;
        check("half_3", halfAct, 3);
        measure_rise(n);
        check("pulse_first", n, 3);
        check("pulse_tick", tick, 1);
        measure_rise(n);
        check("pulse_gap", n, 3);

        // Clear with pending shadow 6
        pulseMode = 1'b0;
        measure_rise(n);
        measure_rise(n);
        check("period_6", n, 6);
        divLoad = 1'b1; divIn = 8'd6;
        cyc(1);
        divLoad = 1'b0;
        check("pend_6", pending, 1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        check("clr_clkOut", clkOut, 0);
        check("clr_half", halfAct, 6);
        check("clr_pend", pending, 0);
        measure_rise(n);
        check("clr_rise_6", n, 6);

        // Asynchronous reset while a load is pending
        divLoad = 1'b1; divIn = 8'd2;
        cyc(1);
        divLoad = 1'b0;
        check("pend_pre_rst", pending, 1);
        #3 rstN = 1'b0;
        #1;
        check("arst_clkOut", clkOut, 0);
        check("arst_tick", tick, 0);
        check("arst_pend", pending, 0);
        check("arst_half", halfAct, 4);
        cyc(2);
        rstN = 1'b1;

        // Load coinciding with a wrap applies immediately
        cyc(3);
        divLoad = 1'b1; divIn = 8'd5;
        cyc(1);
        divLoad = 1'b0;
        check("wrap_pend", pending, 0);
        check("wrap_half", halfAct, 5);

        // Back-to-back loads: last one wins
        divLoad = 1'b1; divIn = 8'd7;
        cyc(1);
        divIn = 8'd9;
        cyc(1);
        divLoad = 1'b0;
        check("dbl_pend", pending, 1);
        k = 0;
        while (pending && k < 20) begin cyc(1); k++; end
        check("dbl_half", halfAct, 9);

        // Freeze, resume, then clear together with a load of 0
        cyc(4);
        en = 1'b0;
        cyc(5);
        en = 1'b1;
        cyc(6);
        clr = 1'b1; divLoad = 1'b1; divIn = 8'd0;
        cyc(1);
        clr = 1'b0; divLoad = 1'b0;
        check("clrld_half", halfAct, 1);
        check("clrld_clkOut", clkOut, 0);
        check("clrld_pend", pending, 0);
        cyc(20);

        chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
